wb_cmd_initiator: RTL and testbench

- Wishbone initiator for the FPGA fabric. It drives the same WBs_* style bus that the AHB-to-FPGA bridge drives into AL4S3B_FPGA_IP, so fabric logic can run register reads and writes on IP blocks without the M4.
- Commands enter through a valid/ready port and are buffered in a small FIFO. Each command runs one single-beat Wishbone cycle.
- Every command returns exactly one response (read data or error) on a valid/ready port. A watchdog aborts cycles that never receive ACK.

---
 rtl/wb_init_pkg.sv | 22 ++
 rtl/wb_cmd_fifo.sv | 73 +++++++
 rtl/wb_cmd_initiator.sv | 182 ++++++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 579 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_init_pkg.sv
// Shared widths, command record and FSM state type for the Wishbone command initiator.
package wb_init_pkg;

    localparam int unsigned ADR_W = 17;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned BE_W  = 4;

    // One queued bus command as it travels through the FIFO.
    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [BE_W-1:0]  be;
    } wb_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } wb_state_e;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Small synchronous command FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module wb_cmd_fifo
    import wb_init_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  wb_cmd_t                wdata_i,
    input  logic                   pop_i,
    output wb_cmd_t                rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_cmd_t         mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone command initiator: buffers register commands from fabric logic and runs each one as
// a single-beat WBs_* cycle, returning exactly one response (data or timeout error) per command.
module wb_cmd_initiator
    import wb_init_pkg::*;
#(
    parameter int unsigned CMD_DEPTH   = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             WB_CLK,
    input  logic             WB_RST_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    input  logic [BE_W-1:0]  cmd_be,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic [ADR_W-1:0] WBm_ADR,
    output logic             WBm_CYC,
    output logic             WBm_STB,
    output logic             WBm_WE,
    output logic             WBm_RD,
    output logic [BE_W-1:0]  WBm_BYTE_STB,
    output logic [DAT_W-1:0] WBm_WR_DAT,
    input  logic [DAT_W-1:0] WBm_RD_DAT,
    input  logic             WBm_ACK,
    output logic             busy
);
    localparam int unsigned CntW    = $clog2(CMD_DEPTH) + 1;
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

    wb_cmd_t         fifo_wdata, fifo_head;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    wb_state_e        state_q, state_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic             rd_q, rd_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [BE_W-1:0]  be_q, be_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             load;

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && !fifo_full;
    assign fifo_wdata = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, be: cmd_be};

    wb_cmd_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_fifo (
        .clk_i  (WB_CLK),
        .rst_ni (WB_RST_n),
        .push_i (fifo_push),
        .wdata_i(fifo_wdata),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    // Next-state for the bus FSM, watchdog and response registers.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        rd_d        = rd_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        load        = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = !fifo_empty;
            end
            StBus: begin
                if (WBm_ACK) begin
                    // ACK beats a timeout that expires on the same edge.
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rd_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = rd_q ? WBm_RD_DAT : '0;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else if (tmo_q == TmoLast) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rd_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (fifo_empty) begin
                        state_d = StIdle;
                    end else begin
                        // Chain straight into the next cycle without an idle bubble.
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            cyc_d    = 1'b1;
            we_d     = fifo_head.we;
            rd_d     = !fifo_head.we;
            adr_d    = fifo_head.adr;
            dat_d    = fifo_head.dat;
            be_d     = fifo_head.be;
            tmo_d    = '0;
            state_d  = StBus;
        end
    end

    // FSM state and every registered bus/response output.
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign WBm_CYC      = cyc_q;
    assign WBm_STB      = cyc_q;
    assign WBm_WE       = we_q;
    assign WBm_RD       = rd_q;
    assign WBm_ADR      = adr_q;
    assign WBm_WR_DAT   = dat_q;
    assign WBm_BYTE_STB = be_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_dat      = rsp_dat_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: a Wishbone slave model with per-command ACK latency,
// bus and response monitors, directed scenarios and a randomized run against a queue model.
module tb_wb_cmd_initiator;

    localparam int unsigned TMO = 4;
    localparam int          NRND = 40;

    logic        WB_CLK;
    logic        WB_RST_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [16:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic [16:0] WBm_ADR;
    logic        WBm_CYC, WBm_STB, WBm_WE, WBm_RD, WBm_ACK;
    logic [3:0]  WBm_BYTE_STB;
    logic [31:0] WBm_WR_DAT, WBm_RD_DAT;
    logic        busy;

    wb_cmd_initiator #(
        .CMD_DEPTH  (2),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .WB_CLK      (WB_CLK),
        .WB_RST_n    (WB_RST_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_be      (cmd_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .WBm_ADR     (WBm_ADR),
        .WBm_CYC     (WBm_CYC),
        .WBm_STB     (WBm_STB),
        .WBm_WE      (WBm_WE),
        .WBm_RD      (WBm_RD),
        .WBm_BYTE_STB(WBm_BYTE_STB),
        .WBm_WR_DAT  (WBm_WR_DAT),
        .WBm_RD_DAT  (WBm_RD_DAT),
        .WBm_ACK     (WBm_ACK),
        .busy        (busy)
    );

    // Command as issued, plus how the slave model should answer it (lat 0 = never ACK).
    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [31:0] dat;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdat;
    } cmd_t;

    // One observed bus cycle: fields at CYC rise, cycles CYC was high, idle cycles before it.
    typedef struct {
        logic        we;
        logic        rd;
        logic [16:0] adr;
        logic [31:0] dat;
        logic [3:0]  be;
        int          len;
        int          gap;
    } bus_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    cmd_t        exp_q[$];
    bus_t        obs_bus[$];
    rsp_t        obs_rsp[$];
    int          slv_lat_q[$];
    logic [31:0] slv_dat_q[$];

    int vectors     = 0;
    int miscompares = 0;
    bit rand_done;

    // Slave model state.
    int          s_cnt, s_idle, s_lat;
    logic [31:0] s_dat;
    bit          s_in;
    bus_t        s_cur;

    initial begin
        WB_CLK = 1'b0;
        forever #5 WB_CLK = ~WB_CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Wishbone slave: ACKs on the lat-th cycle of CYC, records every bus cycle.
    initial begin
        WBm_ACK    = 1'b0;
        WBm_RD_DAT = '0;
        s_in       = 1'b0;
        s_idle     = 0;
        s_cnt      = 0;
        s_lat      = 1;
        s_dat      = '0;
        forever begin
            @(posedge WB_CLK);
            #1;
            WBm_ACK    = 1'b0;
            WBm_RD_DAT = $urandom;
            if (WBm_CYC && WB_RST_n) begin
                if (!s_in) begin
                    s_in      = 1'b1;
                    s_cnt     = 0;
                    s_cur.we  = WBm_WE;
                    s_cur.rd  = WBm_RD;
                    s_cur.adr = WBm_ADR;
                    s_cur.dat = WBm_WR_DAT;
                    s_cur.be  = WBm_BYTE_STB;
                    s_cur.gap = s_idle;
                    if (slv_lat_q.size() > 0) begin
                        s_lat = slv_lat_q.pop_front();
                        s_dat = slv_dat_q.pop_front();
                    end else begin
                        s_lat = 1;
                        s_dat = '0;
                    end
                end
                s_cnt++;
                if (s_lat != 0 && s_cnt == s_lat) begin
                    WBm_ACK    = 1'b1;
                    WBm_RD_DAT = s_dat;
                end
            end else begin
                if (s_in) begin
                    s_cur.len = s_cnt;
                    obs_bus.push_back(s_cur);
                    s_in   = 1'b0;
                    s_idle = 0;
                end
                s_idle++;
            end
        end
    end

    // Response monitor: a handshake seen mid-cycle completes on the next rising edge.
    initial begin
        forever begin
            @(negedge WB_CLK);
            if (WB_RST_n && rsp_valid && rsp_ready) begin
                obs_rsp.push_back('{rsp_dat, rsp_err});
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        obs_bus.delete();
        obs_rsp.delete();
        slv_lat_q.delete();
        slv_dat_q.delete();
    endtask

    task automatic send_cmd(input logic we, input logic [16:0] adr, input logic [31:0] dat,
                            input logic [3:0] be, input int lat, input logic [31:0] rdat);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_be    = be;
        @(negedge WB_CLK);
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge WB_CLK);
            waited++;
        end
        @(posedge WB_CLK);
        #1;
        cmd_valid = 1'b0;
        vectors++;
        if (waited >= 200) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%b after 200 cycles, required 1", cmd_ready);
        end else begin
            exp_q.push_back('{we, adr, dat, be, lat, rdat});
            slv_lat_q.push_back(lat);
            slv_dat_q.push_back(rdat);
        end
    endtask

    // Waits (bounded) for n responses, then a few more cycles so extras would show up.
    task automatic wait_rsps(input int n);
        int k = 0;
        while (obs_rsp.size() < n && k < 400) begin
            @(posedge WB_CLK);
            #1;
            k++;
        end
        repeat (3) @(posedge WB_CLK);
        #1;
    endtask

    task automatic test_reset();
        WB_RST_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_be    = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge WB_CLK);
        #1;
        vectors++;
        if ({WBm_CYC, WBm_STB, WBm_WE, WBm_RD, rsp_valid, rsp_err, busy} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: cyc/stb/we/rd/rsp_valid/rsp_err/busy=%b, required 0000000",
                     {WBm_CYC, WBm_STB, WBm_WE, WBm_RD, rsp_valid, rsp_err, busy});
        end
        vectors++;
        if ({WBm_ADR, WBm_WR_DAT, WBm_BYTE_STB, rsp_dat} !== 85'd0) begin
            miscompares++;
            $display("FAIL reset_data: adr=%h wdat=%h be=%h rsp_dat=%h, required all 0",
                     WBm_ADR, WBm_WR_DAT, WBm_BYTE_STB, rsp_dat);
        end
        WB_RST_n = 1'b1;
        @(posedge WB_CLK);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        clear_model();
    endtask

    task automatic test_single_write();
        bus_t b;
        rsp_t r;
        clear_model();
        rsp_ready = 1'b1;
        send_cmd(1'b1, 17'h00104, 32'hA5A5_1234, 4'hF, 1, 32'hDEAD_BEEF);
        vectors++;
        if (WBm_CYC !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_latency1: CYC=%b one cycle after accept, required 0", WBm_CYC);
        end
        @(posedge WB_CLK);
        #1;
        vectors++;
        if ({WBm_CYC, WBm_STB, WBm_WE, WBm_RD} !== 4'b1110) begin
            miscompares++;
            $display("FAIL wr_latency2: cyc/stb/we/rd=%b, required 1110",
                     {WBm_CYC, WBm_STB, WBm_WE, WBm_RD});
        end
        wait_rsps(1);
        vectors++;
        if (obs_bus.size() != 1 || obs_rsp.size() != 1) begin
            miscompares++;
            $display("FAIL wr_count: bus=%0d rsp=%0d, required 1 and 1", obs_bus.size(),
                     obs_rsp.size());
        end else begin
            b = obs_bus[0];
            r = obs_rsp[0];
            vectors++;
            if ({b.we, b.rd, b.adr, b.dat, b.be, b.len} !==
                {1'b1, 1'b0, 17'h00104, 32'hA5A5_1234, 4'hF, 32'd1}) begin
                miscompares++;
                $display("FAIL wr_bus: we=%b rd=%b adr=%h dat=%h be=%h len=%0d, required 1 0 00104 a5a51234 f 1",
                         b.we, b.rd, b.adr, b.dat, b.be, b.len);
            end
            vectors++;
            if ({r.dat, r.err} !== 33'd0) begin
                miscompares++;
                $display("FAIL wr_rsp: dat=%h err=%b, required 00000000 0", r.dat, r.err);
            end
        end
        vectors++;
        if ({WBm_ADR, WBm_WR_DAT, WBm_BYTE_STB, busy} !== {17'h00104, 32'hA5A5_1234, 4'hF, 1'b0})
        begin
            miscompares++;
            $display("FAIL wr_hold: adr=%h wdat=%h be=%h busy=%b, required 00104 a5a51234 f 0",
                     WBm_ADR, WBm_WR_DAT, WBm_BYTE_STB, busy);
        end
    endtask

    task automatic test_single_read();
        bus_t b;
        rsp_t r;
        clear_model();
        rsp_ready = 1'b1;
        send_cmd(1'b0, 17'h00000, 32'h1111_2222, 4'hF, 3, 32'h0001_0203);
        wait_rsps(1);
        vectors++;
        if (obs_bus.size() != 1 || obs_rsp.size() != 1) begin
            miscompares++;
            $display("FAIL rd_count: bus=%0d rsp=%0d, required 1 and 1", obs_bus.size(),
                     obs_rsp.size());
        end else begin
            b = obs_bus[0];
            r = obs_rsp[0];
            vectors++;
            if ({b.we, b.rd, b.adr, b.be, b.len} !== {1'b0, 1'b1, 17'h0, 4'hF, 32'd3}) begin
                miscompares++;
                $display("FAIL rd_bus: we=%b rd=%b adr=%h be=%h len=%0d, required 0 1 00000 f 3",
                         b.we, b.rd, b.adr, b.be, b.len);
            end
            vectors++;
            if ({r.dat, r.err} !== {32'h0001_0203, 1'b0}) begin
                miscompares++;
                $display("FAIL rd_rsp: dat=%h err=%b, required 00010203 0", r.dat, r.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] adrs [3];
        adrs[0] = 17'h00010;
        adrs[1] = 17'h00020;
        adrs[2] = 17'h00030;
        clear_model();
        rsp_ready = 1'b1;
        send_cmd(1'b1, adrs[0], 32'h0000_00AA, 4'h1, 1, 32'h0);
        send_cmd(1'b0, adrs[1], 32'h0, 4'hF, 1, 32'h7777_8888);
        send_cmd(1'b1, adrs[2], 32'h0000_00CC, 4'h3, 1, 32'h0);
        wait_rsps(3);
        vectors++;
        if (obs_bus.size() != 3 || obs_rsp.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_count: bus=%0d rsp=%0d, required 3 and 3", obs_bus.size(),
                     obs_rsp.size());
        end else begin
            vectors++;
            if ({obs_bus[0].we, obs_bus[0].adr, obs_bus[1].we, obs_bus[1].adr, obs_bus[2].we,
                 obs_bus[2].adr} !== {1'b1, adrs[0], 1'b0, adrs[1], 1'b1, adrs[2]}) begin
                miscompares++;
                $display("FAIL b2b_order: %b/%h %b/%h %b/%h, required 1/00010 0/00020 1/00030",
                         obs_bus[0].we, obs_bus[0].adr, obs_bus[1].we, obs_bus[1].adr,
                         obs_bus[2].we, obs_bus[2].adr);
            end
            vectors++;
            if (obs_bus[1].gap != 1 || obs_bus[2].gap != 1) begin
                miscompares++;
                $display("FAIL b2b_gap: gaps %0d %0d, required 1 1", obs_bus[1].gap,
                         obs_bus[2].gap);
            end
            vectors++;
            if ({obs_rsp[0].dat, obs_rsp[1].dat, obs_rsp[2].dat} !== {32'h0, 32'h7777_8888, 32'h0})
            begin
                miscompares++;
                $display("FAIL b2b_rsp: %h %h %h, required 00000000 77778888 00000000",
                         obs_rsp[0].dat, obs_rsp[1].dat, obs_rsp[2].dat);
            end
        end
    endtask

    task automatic test_timeout();
        clear_model();
        rsp_ready = 1'b1;
        send_cmd(1'b0, 17'h00155, 32'h0, 4'hF, 0, 32'h9999_9999);
        send_cmd(1'b1, 17'h00156, 32'h1357_9BDF, 4'h8, 2, 32'h0);
        wait_rsps(2);
        vectors++;
        if (obs_bus.size() != 2 || obs_rsp.size() != 2) begin
            miscompares++;
            $display("FAIL tmo_count: bus=%0d rsp=%0d, required 2 and 2", obs_bus.size(),
                     obs_rsp.size());
        end else begin
            vectors++;
            if (obs_bus[0].len != int'(TMO)) begin
                miscompares++;
                $display("FAIL tmo_len: CYC high %0d cycles, required %0d", obs_bus[0].len, TMO);
            end
            vectors++;
            if ({obs_rsp[0].dat, obs_rsp[0].err} !== {32'h0, 1'b1}) begin
                miscompares++;
                $display("FAIL tmo_rsp: dat=%h err=%b, required 00000000 1", obs_rsp[0].dat,
                         obs_rsp[0].err);
            end
            vectors++;
            if ({obs_bus[1].we, obs_bus[1].adr, obs_bus[1].dat, obs_bus[1].len, obs_rsp[1].err} !==
                {1'b1, 17'h00156, 32'h1357_9BDF, 32'd2, 1'b0}) begin
                miscompares++;
                $display("FAIL tmo_next: we=%b adr=%h dat=%h len=%0d err=%b, required 1 00156 13579bdf 2 0",
                         obs_bus[1].we, obs_bus[1].adr, obs_bus[1].dat, obs_bus[1].len,
                         obs_rsp[1].err);
            end
        end
    endtask

    task automatic test_full_backpressure();
        int ready_seen = 0;
        int unstable   = 0;
        clear_model();
        rsp_ready = 1'b0;
        send_cmd(1'b0, 17'h00200, 32'h0, 4'hF, 1, 32'hCAFE_F00D);
        send_cmd(1'b1, 17'h00201, 32'h0BAD_0001, 4'h5, 2, 32'h0);
        send_cmd(1'b0, 17'h00202, 32'h0, 4'hA, 1, 32'h1234_5678);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 17'h00203;
        cmd_dat   = 32'hFFFF_0000;
        cmd_be    = 4'hF;
        repeat (10) begin
            @(negedge WB_CLK);
            if (cmd_ready !== 1'b0) ready_seen++;
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE_F00D) unstable++;
        end
        @(posedge WB_CLK);
        #1;
        cmd_valid = 1'b0;
        vectors++;
        if (ready_seen != 0) begin
            miscompares++;
            $display("FAIL full_ready: cmd_ready high on %0d stalled cycles, required 0", ready_seen);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL full_hold: response unstable on %0d cycles, required 0", unstable);
        end
        vectors++;
        if (obs_bus.size() != 1 || WBm_CYC !== 1'b0) begin
            miscompares++;
            $display("FAIL full_nobus: bus cycles=%0d CYC=%b, required 1 0", obs_bus.size(),
                     WBm_CYC);
        end
        rsp_ready = 1'b1;
        wait_rsps(3);
        vectors++;
        if (obs_rsp.size() != 3 || obs_bus.size() != 3) begin
            miscompares++;
            $display("FAIL full_drain: rsp=%0d bus=%0d, required 3 and 3", obs_rsp.size(),
                     obs_bus.size());
        end else begin
            vectors++;
            if ({obs_rsp[0].dat, obs_rsp[1].dat, obs_rsp[2].dat, obs_rsp[0].err, obs_rsp[1].err,
                 obs_rsp[2].err} !== {32'hCAFE_F00D, 32'h0, 32'h1234_5678, 3'b000}) begin
                miscompares++;
                $display("FAIL full_rsp: %h %h %h err %b%b%b, required cafef00d 00000000 12345678 err 000",
                         obs_rsp[0].dat, obs_rsp[1].dat, obs_rsp[2].dat, obs_rsp[0].err,
                         obs_rsp[1].err, obs_rsp[2].err);
            end
            vectors++;
            if ({obs_bus[1].adr, obs_bus[1].dat, obs_bus[1].be, obs_bus[2].adr, obs_bus[2].be} !==
                {17'h00201, 32'h0BAD_0001, 4'h5, 17'h00202, 4'hA}) begin
                miscompares++;
                $display("FAIL full_bus: %h/%h/%h %h/%h, required 00201/0bad0001/5 00202/a",
                         obs_bus[1].adr, obs_bus[1].dat, obs_bus[1].be, obs_bus[2].adr,
                         obs_bus[2].be);
            end
        end
    endtask

    task automatic test_reset_mid_cycle();
        clear_model();
        rsp_ready = 1'b1;
        send_cmd(1'b0, 17'h1AAAA, 32'h0, 4'hF, 0, 32'h0);
        send_cmd(1'b1, 17'h1BBBB, 32'h5555_AAAA, 4'hF, 1, 32'h0);
        vectors++;
        if (WBm_CYC !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: CYC=%b before reset, required 1", WBm_CYC);
        end
        #2;
        WB_RST_n = 1'b0;
        #1;
        vectors++;
        if ({WBm_CYC, WBm_STB, rsp_valid, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_drop: cyc/stb/rsp_valid/busy=%b, required 0000",
                     {WBm_CYC, WBm_STB, rsp_valid, busy});
        end
        @(posedge WB_CLK);
        #1;
        WB_RST_n = 1'b1;
        repeat (3) @(posedge WB_CLK);
        #1;
        vectors++;
        if (busy !== 1'b0 || obs_rsp.size() != 0 || WBm_CYC !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_flush: busy=%b rsp=%0d CYC=%b, required 0 0 0", busy,
                     obs_rsp.size(), WBm_CYC);
        end
        clear_model();
        send_cmd(1'b1, 17'h0BEEF, 32'h0F0F_0F0F, 4'h6, 2, 32'h0);
        wait_rsps(1);
        vectors++;
        if (obs_bus.size() != 1 || obs_rsp.size() != 1) begin
            miscompares++;
            $display("FAIL rstmid_count: bus=%0d rsp=%0d, required 1 and 1", obs_bus.size(),
                     obs_rsp.size());
        end else begin
            vectors++;
            if ({obs_bus[0].we, obs_bus[0].adr, obs_bus[0].dat, obs_bus[0].be, obs_bus[0].len,
                 obs_rsp[0].dat, obs_rsp[0].err} !==
                {1'b1, 17'h0BEEF, 32'h0F0F_0F0F, 4'h6, 32'd2, 32'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL rstmid_after: we=%b adr=%h dat=%h be=%h len=%0d rsp=%h/%b, required 1 0beef 0f0f0f0f 6 2 00000000/0",
                         obs_bus[0].we, obs_bus[0].adr, obs_bus[0].dat, obs_bus[0].be,
                         obs_bus[0].len, obs_rsp[0].dat, obs_rsp[0].err);
            end
        end
    endtask

    task automatic test_random();
        clear_model();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < NRND; i++) begin
                    send_cmd(1'($urandom_range(0, 1)), 17'($urandom), $urandom,
                             4'($urandom_range(0, 15)), int'($urandom_range(0, 6)), $urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge WB_CLK);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_rsps(NRND);
        vectors++;
        if (obs_rsp.size() != NRND || obs_bus.size() != NRND || exp_q.size() != NRND) begin
            miscompares++;
            $display("FAIL rnd_count: rsp=%0d bus=%0d cmds=%0d, required %0d each", obs_rsp.size(),
                     obs_bus.size(), exp_q.size(), NRND);
        end else begin
            for (int i = 0; i < NRND; i++) begin
                cmd_t        c;
                bit          e_err;
                logic [31:0] e_dat;
                int          e_len;
                c     = exp_q[i];
                e_err = (c.lat == 0) || (c.lat > int'(TMO));
                e_dat = (e_err || c.we) ? 32'h0 : c.rdat;
                e_len = e_err ? int'(TMO) : c.lat;
                vectors++;
                if ({obs_rsp[i].dat, obs_rsp[i].err} !== {e_dat, e_err}) begin
                    miscompares++;
                    $display("FAIL rnd_rsp[%0d]: dat=%h err=%b, required dat=%h err=%b", i,
                             obs_rsp[i].dat, obs_rsp[i].err, e_dat, e_err);
                end
                vectors++;
                if ({obs_bus[i].we, obs_bus[i].rd, obs_bus[i].adr, obs_bus[i].dat, obs_bus[i].be,
                     obs_bus[i].len} !== {c.we, !c.we, c.adr, c.dat, c.be, e_len}) begin
                    miscompares++;
                    $display("FAIL rnd_bus[%0d]: we=%b rd=%b adr=%h dat=%h be=%h len=%0d, required %b %b %h %h %h %0d",
                             i, obs_bus[i].we, obs_bus[i].rd, obs_bus[i].adr, obs_bus[i].dat,
                             obs_bus[i].be, obs_bus[i].len, c.we, !c.we, c.adr, c.dat, c.be,
                             e_len);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_full_backpressure();
        test_reset_mid_cycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
